// File: rtl/edge_pack_pkg.sv
// Shared definitions for the edge packer and the Sobel stage that feeds it:
// frame geometry defaults, marker byte, pixel colour constants, state encoding.
package edge_pack_pkg;

  // Default frame geometry of the binary edge image.
  localparam int COL_MAX_DEF    = 98;
  localparam int ROW_MAX_DEF    = 98;

  // Default depth of the output byte buffer (power of 2).
  localparam int FIFO_DEPTH_DEF = 16;

  // Marker byte emitted ahead of every frame.
  localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;

  // Pixel colours produced by the Sobel stage.
  localparam logic [7:0] PIX_BLACK = 8'h00;  // edge
  localparam logic [7:0] PIX_WHITE = 8'hFF;  // background

  // Packer control states.
  typedef enum logic [0:0] {
    S_IDLE = 1'b0,  // waiting for pixel (row 0, col 0)
    S_PACK = 1'b1   // inside a frame
  } state_t;

  // Edge pixels are black, so the packed bit is the inverse of the MSB.
  function automatic logic pixel_bit(input logic pix_msb);
    return ~pix_msb;
  endfunction

  // One-hot mask for a bit position counted MSB-first inside a byte.
  function automatic logic [7:0] bit_mask(input logic [2:0] pos);
    return 8'h80 >> pos;
  endfunction

endpackage

// File: rtl/edge_pack_fifo.sv
// First-word-fall-through byte buffer. The head entry is presented on rd_data
// whenever the buffer is not empty; a write is visible the cycle after it.
// A simultaneous read and write both take effect, even when full.
module edge_pack_fifo #(
  parameter int DEPTH = 16,  // power of 2, at least 2
  parameter int WIDTH = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop frees a slot on the same edge, so a full buffer still accepts a push.
  assign do_pop  = rd_en && !empty;
  assign do_push = wr_en && (!full || do_pop);

  // No bypass: an empty buffer presents zero, never the incoming byte.
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Storage array write port.
  // NOTE: the data array has no reset; only the pointers define what is valid,
  // and leaving it unreset lets it map onto plain RAM/register-file cells.
  always_ff @(posedge sys_clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // Read/write pointer update.
  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/edge_pack.sv
// Packs a binary edge image, one pixel per pi_flag strobe, into MSB-first
// bytes (one row never shares a byte with the next), prefixes each frame with
// a marker byte and queues everything in a FWFT buffer for the UART side.
// Column width assumes COL_MAX >= 8 so col[2:0] is the bit slot in the byte.
module edge_pack
  import edge_pack_pkg::*;
#(
  parameter int         COL_MAX    = COL_MAX_DEF,
  parameter int         ROW_MAX    = ROW_MAX_DEF,
  parameter int         FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter logic [7:0] HDR_BYTE   = HDR_BYTE_DEF
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       pi_flag,
  input  logic [7:0] pi_data,
  input  logic       po_ready,
  output logic       po_valid,
  output logic [7:0] po_data,
  output logic       frame_done,
  output logic       overflow
);

  localparam int CW = $clog2(COL_MAX);
  localparam int RW = $clog2(ROW_MAX);

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [7:0]    pack;

  logic          pix_on;
  logic          last_col;
  logic          last_row;
  logic [2:0]    bit_pos;
  logic [7:0]    pix_mask;
  logic [7:0]    packed_byte;
  logic          hdr_wr;
  logic          byte_done;
  logic          frame_end;
  logic          fifo_wr;
  logic [7:0]    fifo_din;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_drop;
  logic          pix_unused;

  // Only the MSB of a pixel carries information.
  assign pix_unused = ^pi_data[6:0];

  // Per-pixel datapath: bit placement, byte completion and buffer write.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    pix_on      = 1'b0;
    last_col    = 1'b0;
    last_row    = 1'b0;
    bit_pos     = 3'd0;
    pix_mask    = 8'h00;
    packed_byte = 8'h00;
    hdr_wr      = 1'b0;
    byte_done   = 1'b0;
    frame_end   = 1'b0;
    fifo_wr     = 1'b0;
    fifo_din    = 8'h00;

    pix_on      = pi_flag && !sys_rst;
    last_col    = (col == CW'(COL_MAX - 1));
    last_row    = (row == RW'(ROW_MAX - 1));
    bit_pos     = col[2:0];
    pix_mask    = pixel_bit(pi_data[7]) ? bit_mask(bit_pos) : 8'h00;
    packed_byte = pack | pix_mask;

    // The first pixel of a frame always arrives in S_IDLE.
    hdr_wr      = pix_on && (state == S_IDLE);
    byte_done   = pix_on && ((bit_pos == 3'd7) || last_col);
    frame_end   = pix_on && last_col && last_row;

    // Header and a completed byte cannot coincide while COL_MAX >= 2.
    fifo_wr     = hdr_wr || byte_done;
    fifo_din    = hdr_wr ? HDR_BYTE : packed_byte;
  end

  // A write into a full buffer is lost unless a read frees a slot that edge.
  assign fifo_drop = fifo_wr && fifo_full && !(po_ready && !fifo_empty);

  // Frame FSM with counters, pack register and registered status flags.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= S_IDLE;
      col        <= '0;
      row        <= '0;
      pack       <= 8'h00;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (fifo_drop) begin
        overflow <= 1'b1;
      end

      if (pix_on) begin
        // Pack register: restart on the frame's first pixel, clear on completion.
        if (byte_done) begin
          pack <= 8'h00;
        end else if (state == S_IDLE) begin
          pack <= pix_mask;
        end else begin
          pack <= packed_byte;
        end

        // Raster position, wrapping at the end of the row and of the frame.
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end

        case (state)
          S_IDLE: begin
            state <= S_PACK;
          end
          S_PACK: begin
            if (frame_end) begin
              state      <= S_IDLE;
              frame_done <= 1'b1;
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  edge_pack_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .wr_en   (fifo_wr),
    .wr_data (fifo_din),
    .rd_en   (po_ready),
    .rd_data (po_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign po_valid = !fifo_empty;

endmodule

// File: tb/tb_edge_pack.sv
// Scoreboard bench for edge_pack: the pixel driver pushes the bytes each
// pixel should produce; a monitor pops and compares on every transfer.
module tb_edge_pack;
  import edge_pack_pkg::*;

  localparam int COLS = 98;
  localparam int ROWS = 98;
  localparam int DRAIN_LIMIT = 4000;

  logic       sys_clk  = 1'b0;
  logic       sys_rst  = 1'b1;
  logic       pi_flag  = 1'b0;
  logic [7:0] pi_data  = 8'h00;
  logic       po_ready = 1'b0;
  logic       po_valid;
  logic [7:0] po_data;
  logic       frame_done;
  logic       overflow;

  edge_pack dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .pi_flag    (pi_flag),
    .pi_data    (pi_data),
    .po_ready   (po_ready),
    .po_valid   (po_valid),
    .po_data    (po_data),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  always #5 sys_clk = ~sys_clk;

  int         n_checks   = 0;
  int         n_fail     = 0;
  int         xfer_cnt   = 0;
  int         done_cnt   = 0;
  int         keep_limit = -1;
  int         kept       = 0;
  int         m_col      = 0;
  int         m_row      = 0;
  logic [7:0] m_pack     = 8'h00;
  logic [7:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected byte into the scoreboard; when a keep limit is set, bytes past
  // it are the ones the full buffer is expected to drop.
  task automatic expect_byte(input logic [7:0] b);
    if (keep_limit < 0 || kept < keep_limit) begin
      exp_q.push_back(b);
      kept++;
    end
  endtask

  // Monitor: compare every byte actually transferred downstream.
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (frame_done) done_cnt++;
      if (po_valid && po_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte: got %0h, expected no byte", po_data);
        end else begin
          check("byte", {24'h0, po_data}, {24'h0, exp_q.pop_front()});
        end
        xfer_cnt++;
      end
    end
  end

  // Drive one pixel for one cycle and record the bytes it should produce.
  task automatic pixel(input logic [7:0] d);
    pi_flag = 1'b1;
    pi_data = d;
    if (m_col == 0 && m_row == 0) begin
      expect_byte(HDR_BYTE_DEF);
      m_pack = 8'h00;
    end
    if (d[7] == 1'b0) m_pack[7 - (m_col % 8)] = 1'b1;
    if ((m_col % 8) == 7 || m_col == COLS - 1) begin
      expect_byte(m_pack);
      m_pack = 8'h00;
    end
    if (m_col == COLS - 1) begin
      m_col = 0;
      m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
    end else begin
      m_col++;
    end
    @(posedge sys_clk);
    #1;
    pi_flag = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b1;
    pi_flag = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    check("rst_valid",      {31'h0, po_valid},   32'h0);
    check("rst_data",       {24'h0, po_data},    32'h0);
    check("rst_frame_done", {31'h0, frame_done}, 32'h0);
    check("rst_overflow",   {31'h0, overflow},   32'h0);
    sys_rst = 1'b0;
    exp_q.delete();
    m_col = 0; m_row = 0; m_pack = 8'h00;
    xfer_cnt = 0; done_cnt = 0; kept = 0; keep_limit = -1;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || po_valid) && t < DRAIN_LIMIT) begin
      @(posedge sys_clk);
      #1;
      t++;
    end
    check(name, {31'h0, (t < DRAIN_LIMIT)}, 32'h1);
  endtask

  initial begin
    po_ready = 1'b1;

    // Single byte: header then 81; output appears one cycle after pixel 0.
    do_reset();
    check("idle_valid", {31'h0, po_valid}, 32'h0);
    pixel(PIX_BLACK);
    check("first_valid", {31'h0, po_valid}, 32'h1);
    check("first_hdr",   {24'h0, po_data},  32'hA5);
    for (int i = 0; i < 6; i++) pixel(PIX_WHITE);
    pixel(PIX_BLACK);
    drain("drain_basic");
    check("basic_count", xfer_cnt, 32'd2);

    // All-edge row: A5, 12 x FF, C0; column counter back at 0.
    do_reset();
    for (int c = 0; c < COLS; c++) pixel(PIX_BLACK);
    drain("drain_row");
    check("row_count",     xfer_cnt, 32'd14);
    check("col_after_row", {25'h0, dut.col}, 32'h0);
    check("row_after_row", {25'h0, dut.row}, 32'h1);

    // Full frame of alternating pixels: 1275 bytes (AA.., 80 at row end).
    do_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        pixel((c % 2 == 0) ? PIX_BLACK : PIX_WHITE);
    drain("drain_frame");
    check("frame_count", xfer_cnt, 32'd1275);
    check("frame_done_pulses", done_cnt, 32'd1);
    pixel(PIX_BLACK);
    drain("drain_next_hdr");
    check("next_frame_hdr", xfer_cnt, 32'd1276);
    check("frame_done_once", done_cnt, 32'd1);

    // Stalled output across two rows: first 16 bytes held, rest dropped.
    do_reset();
    po_ready   = 1'b0;
    keep_limit = 16;
    for (int c = 0; c < COLS; c++) pixel((c % 3 == 0) ? PIX_BLACK : PIX_WHITE);
    check("ovf_not_yet", {31'h0, overflow}, 32'h0);
    check("held_valid",  {31'h0, po_valid}, 32'h1);
    for (int c = 0; c < COLS; c++) pixel((c % 3 == 0) ? PIX_BLACK : PIX_WHITE);
    check("ovf_set",     {31'h0, overflow}, 32'h1);
    check("held_stable", {24'h0, po_data},  32'hA5);
    check("held_no_xfer", xfer_cnt, 32'd0);
    po_ready = 1'b1;
    drain("drain_ovf");
    check("ovf_drained",  xfer_cnt, 32'd16);
    check("ovf_sticky",   {31'h0, overflow}, 32'h1);

    // Full buffer, byte completes while a pop happens: nothing lost.
    do_reset();
    po_ready = 1'b0;
    for (int c = 0; c < COLS + 16; c++) pixel((c % 2 == 0) ? PIX_WHITE : PIX_BLACK);
    check("full_no_ovf", {31'h0, overflow}, 32'h0);
    for (int c = 0; c < 7; c++) pixel(PIX_BLACK);
    po_ready = 1'b1;
    pixel(PIX_WHITE);
    po_ready = 1'b0;
    check("push_pop_full_ovf", {31'h0, overflow}, 32'h0);
    check("push_pop_full_xfer", xfer_cnt, 32'd1);
    po_ready = 1'b1;
    drain("drain_full");
    check("full_total", xfer_cnt, 32'd17);
    check("full_ovf_end", {31'h0, overflow}, 32'h0);

    // Reset after 5 pixels of row 3, then a fresh frame start.
    do_reset();
    for (int c = 0; c < 3 * COLS + 5; c++) pixel(PIX_WHITE);
    check("pre_reset_drained", exp_q.size(), 32'd0);
    do_reset();
    pixel(PIX_BLACK);
    pixel(PIX_BLACK);
    for (int i = 0; i < 6; i++) pixel(PIX_WHITE);
    drain("drain_restart");
    check("restart_count", xfer_cnt, 32'd2);
    check("restart_col",   {25'h0, dut.col}, 32'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
